// File: rtl/box_group_accum.sv
// Groups consecutive valid pixel samples into sums of up to GROUP_LEN for the averaging divider.
// Latency: group emitted 1 cycle after its closing sample; sideband delayed DIV_LAT more cycles.
// No backpressure: a sample is consumed on every cycle in_valid is high.
module box_group_accum #(
  parameter int PIX_W     = 6,
  parameter int GROUP_LEN = 8,
  parameter int DIV_LAT   = 1
) (
  input  logic             clock,
  input  logic             aclr,
  input  logic             in_valid,
  input  logic [PIX_W-1:0] in_pix,
  input  logic             in_eol,
  input  logic             in_sof,
  output logic [9:0]       numer,
  output logic [3:0]       denom,
  output logic             grp_valid,
  output logic             grp_eol,
  output logic [7:0]       grp_idx,
  output logic             out_valid,
  output logic             out_eol,
  output logic             partial_drop
);

  localparam logic [3:0] GRP_CNT = 4'(GROUP_LEN);

  typedef enum logic {
    ST_EMPTY,
    ST_ACCUM
  } state_t;

  state_t state_q, state_d;

  logic [9:0] acc_sum_q, acc_sum_d;
  logic [3:0] acc_cnt_q, acc_cnt_d;
  logic [7:0] line_idx_q, line_idx_d;

  logic [9:0] numer_q, numer_d;
  logic [3:0] denom_q, denom_d;
  logic       grp_valid_q, grp_valid_d;
  logic       grp_eol_q, grp_eol_d;
  logic [7:0] grp_idx_q, grp_idx_d;
  logic       partial_drop_q, partial_drop_d;

  logic [DIV_LAT-1:0] vld_dly_q, vld_dly_d;
  logic [DIV_LAT-1:0] eol_dly_q, eol_dly_d;

  // Starting point for this cycle's sample: in_sof wipes the partial group and line position first.
  logic [9:0] base_sum;
  logic [3:0] base_cnt;
  logic [7:0] base_idx;
  logic [9:0] nsum;
  logic [3:0] ncnt;
  logic       close_grp;

  // Candidate sum/count if the current sample joins the group, and whether it closes it.
  always_comb begin
    base_sum  = in_sof ? 10'd0 : acc_sum_q;
    base_cnt  = in_sof ? 4'd0  : acc_cnt_q;
    base_idx  = in_sof ? 8'd0  : line_idx_q;
    nsum      = base_sum + 10'(in_pix);
    ncnt      = base_cnt + 4'd1;
    close_grp = in_valid && ((ncnt == GRP_CNT) || in_eol);
  end

  // State register: EMPTY when no samples are pending, ACCUM otherwise.
  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, accumulator update and group emit; divider inputs hold between groups.
  always_comb begin
    state_d        = state_q;
    acc_sum_d      = acc_sum_q;
    acc_cnt_d      = acc_cnt_q;
    line_idx_d     = base_idx;
    numer_d        = numer_q;
    denom_d        = denom_q;
    grp_eol_d      = grp_eol_q;
    grp_idx_d      = grp_idx_q;
    grp_valid_d    = 1'b0;
    partial_drop_d = 1'b0;

    unique case (state_q)
      ST_EMPTY: partial_drop_d = 1'b0;
      ST_ACCUM: partial_drop_d = in_sof;
      default:  partial_drop_d = 1'b0;
    endcase

    if (in_sof) begin
      state_d   = ST_EMPTY;
      acc_sum_d = 10'd0;
      acc_cnt_d = 4'd0;
    end

    if (in_valid) begin
      if (close_grp) begin
        numer_d     = nsum;
        denom_d     = ncnt;
        grp_valid_d = 1'b1;
        grp_eol_d   = in_eol;
        grp_idx_d   = base_idx;
        acc_sum_d   = 10'd0;
        acc_cnt_d   = 4'd0;
        state_d     = ST_EMPTY;
        // Index wraps naturally at 8 bits; end of line restarts numbering.
        line_idx_d  = in_eol ? 8'd0 : base_idx + 8'd1;
      end else begin
        acc_sum_d = nsum;
        acc_cnt_d = ncnt;
        state_d   = ST_ACCUM;
      end
    end
  end

  // Sideband shift: stage 0 takes the registered group flags, later stages follow.
  always_comb begin
    vld_dly_d    = vld_dly_q;
    eol_dly_d    = eol_dly_q;
    vld_dly_d[0] = grp_valid_q;
    eol_dly_d[0] = grp_eol_q;
    for (int i = 1; i < DIV_LAT; i++) begin
      vld_dly_d[i] = vld_dly_q[i-1];
      eol_dly_d[i] = eol_dly_q[i-1];
    end
  end

  // Datapath and sideband registers; denom resets to 1 so the divider never divides by zero.
  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      acc_sum_q      <= 10'd0;
      acc_cnt_q      <= 4'd0;
      line_idx_q     <= 8'd0;
      numer_q        <= 10'd0;
      denom_q        <= 4'd1;
      grp_valid_q    <= 1'b0;
      grp_eol_q      <= 1'b0;
      grp_idx_q      <= 8'd0;
      partial_drop_q <= 1'b0;
      vld_dly_q      <= '0;
      eol_dly_q      <= '0;
    end else begin
      acc_sum_q      <= acc_sum_d;
      acc_cnt_q      <= acc_cnt_d;
      line_idx_q     <= line_idx_d;
      numer_q        <= numer_d;
      denom_q        <= denom_d;
      grp_valid_q    <= grp_valid_d;
      grp_eol_q      <= grp_eol_d;
      grp_idx_q      <= grp_idx_d;
      partial_drop_q <= partial_drop_d;
      vld_dly_q      <= vld_dly_d;
      eol_dly_q      <= eol_dly_d;
    end
  end

  assign numer        = numer_q;
  assign denom        = denom_q;
  assign grp_valid    = grp_valid_q;
  assign grp_eol      = grp_eol_q;
  assign grp_idx      = grp_idx_q;
  assign partial_drop = partial_drop_q;
  assign out_valid    = vld_dly_q[DIV_LAT-1];
  assign out_eol      = eol_dly_q[DIV_LAT-1];

endmodule
